adc_capture: RTL and testbench
==============================

// Module: adc_capture
// PURPOSE
//  Triggered capture buffer for the 14-bit ADC input path. It is the receive-side counterpart of the DDS/DAC waveform generators.
//  Samples AD_DATA at a decimated rate into a circular RAM and detects a level/edge trigger. It keeps a programmable pre-trigger history,
//  then streams the frozen record out oldest-first over a valid/ready port to the host/UART readout logic.
// PARAMETERS
//  DW  14  sample width (matches DAC/ADC data width)
//  AW  9   buffer address width; DEPTH = 2**AW = 512 samples
// PORTS
//  clk         in   1   system clock, all logic rising-edge
//  rst         in   1   synchronous reset, active-high
//  en          in   1   sampling enable; 0 pauses capture, readout unaffected
//  AD_DATA     in   DW  raw ADC sample, unsigned offset-binary (8192 = mid)
//  decim       in   12  decimation: one sample kept every decim+1 clocks
//  trig_level  in   DW  trigger threshold, unsigned
//  trig_edge   in   1   0 = rising, 1 = falling
//  pre_len     in   AW  samples retained before trigger (0..DEPTH-1)
//  arm         in   1   1-cycle pulse: start a capture (ignored unless IDLE)
//  force_trig  in   1   pulse: trigger immediately in WAIT
//  busy        out  1   high in any state except IDLE
//  triggered   out  1   set on trigger, cleared on arm or rst
//  rd_data     out  DW  streamed sample
//  rd_valid    out  1   rd_data valid
//  rd_ready    in   1   consumer accepts when rd_valid & rd_ready
//  rd_last     out  1   high with the final (DEPTH-th) sample
// BEHAVIOUR
//  Reset: state=IDLE; wr_ptr, rd count, div_cnt, fill count = 0; busy, triggered, rd_valid, rd_last = 0; rd_data = 0.
//  Input regs: ad_q <= AD_DATA every clk. Sample strobe s_stb is asserted when en & div_cnt==0.
//   div_cnt counts 0..decim and wraps; it is held when en=0 and cleared on arm. decim=0 strobes every enabled clk.
//  On each s_stb in FILL/WAIT/POST: RAM[wr_ptr] <= ad_q; wr_ptr <= wr_ptr+1 mod DEPTH (wraps 511->0).
//  Edge detect uses prev (last stored sample) and cur (ad_q). prev_ok clears on arm and sets after the first sample.
//   rising:  prev_ok & prev <  trig_level & cur >= trig_level
//   falling: prev_ok & prev >  trig_level & cur <= trig_level
//  FSM:
//   IDLE -arm-> FILL. Clears triggered and fill count, and latches pre_len -> pl, decim, trig_edge.
//   FILL: on each s_stb, fill++. When fill==pl, go to WAIT; pl=0 goes directly to WAIT. Triggers are ignored in FILL.
//   WAIT: keeps writing circularly. On s_stb with an edge, or on force_trig, go to POST.
//    trig_addr = address written on that strobe. For force_trig without a strobe, trig_addr = wr_ptr, written at the next strobe.
//    Set triggered=1 and post_cnt=0.
//   POST: count stored samples, including the trigger sample, until DEPTH-pl stored, then go to READ. Start addr = trig_addr-pl mod DEPTH.
//   READ: stream DEPTH samples from start addr, incrementing mod DEPTH.
//    RAM read latency is 1 clk; rd_valid rises 2 clks after entering READ.
//    rd_data/rd_valid/rd_last must hold stable while rd_valid & !rd_ready, with no drop or duplicate (prefetch/skid as needed).
//    Throughput is 1 sample/clk with rd_ready held high.
//    After the handshake with rd_last, the next clk goes to IDLE and rd_valid=0.
//  arm outside IDLE: ignored. force_trig outside WAIT: ignored. Edge and force_trig in the same cycle: a single trigger.
//  en=0 mid-capture: state and counters are frozen and the record resumes on en=1. prev_ok is kept.
//  rst mid-capture or mid-read: immediate return to IDLE. RAM contents are don't-care.
// TESTING
//  1 decim=0, pre_len=100, rising, level=8192, ramp AD 0..16383 step 64/clk, arm.
//    -> 512 samples out; sample[100] is the first >=8192; sample[99] <8192; rd_last on #512.
//  2 Falling edge, pre_len=0, decim=3, descending ramp.
//    -> sample[0] is the first <=level; consecutive outputs differ by 4 ramp steps.
//  3 Constant AD=1000, arm, force_trig after 600 clks, pre_len=200.
//    -> triggered=1; 512 samples of 1000 emitted.
//  4 rd_ready toggled by an LFSR (~50%) during readout.
//    -> output equals the ready-always-high record exactly; count=512; rd_data stable while stalled.
//  5 en dropped for 50 clks in WAIT/POST, plus arm pulsed while busy.
//    -> no writes during the pause; arm has no effect; record is continuous in sample index.
//  6 rst asserted mid-POST and mid-READ.
//    -> next clk busy=0, rd_valid=0, triggered=0; a fresh arm completes normally.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture: triggered capture buffer for the 14-bit ADC path.
// Decimated samples are written into a circular RAM while a level/edge
// trigger is watched. Once the post-trigger part of the record is stored,
// the frozen record is streamed out oldest-first over a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for arm, readout idle
// FILL   | collecting the pre-trigger history (pl samples), triggers ignored
// WAIT   | writing circularly, watching for edge or force_trig
// POST   | storing DEPTH-pl samples counted from the trigger sample
// READ   | streaming DEPTH samples starting at trig_addr-pl
module adc_capture #(
    parameter int DW = 14,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] AD_DATA,
    input  logic [11:0]   decim,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_edge,
    input  logic [AW-1:0] pre_len,
    input  logic          arm,
    input  logic          force_trig,
    output logic          busy,
    output logic          triggered,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_last
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_READ} state_t;
    state_t r_state;
    state_t w_state_nxt;

    logic [DW-1:0] r_mem [DEPTH];

    logic [DW-1:0] r_ad_q;
    logic [11:0]   r_div_cnt;
    logic [11:0]   r_decim_l;
    logic          r_edge_l;
    logic [AW-1:0] r_pl;
    logic [AW-1:0] r_fill;
    logic [AW-1:0] r_wr_ptr;
    logic [DW-1:0] r_prev;
    logic          r_prev_ok;
    logic [AW-1:0] r_trig_addr;
    logic [AW:0]   r_post_cnt;
    logic          r_triggered;
    logic [AW-1:0] r_rd_addr;
    logic [AW:0]   r_rd_issued;

    // read pipeline: RAM output stage, output register and one-deep skid
    logic [DW-1:0] r_ram_q;
    logic          r_ram_v;
    logic          r_ram_last;
    logic [DW-1:0] r_out_d;
    logic          r_out_v;
    logic          r_out_last;
    logic [DW-1:0] r_sk_d;
    logic          r_sk_v;
    logic          r_sk_last;

    logic          w_arm_ok;
    logic          w_stb;
    logic [AW:0]   w_post_target;
    logic          w_post_done;
    logic          w_wr;
    logic          w_rise;
    logic          w_fall;
    logic          w_edge;
    logic          w_trig;
    logic          w_fire;
    logic [1:0]    w_occ_nxt;
    logic          w_issue;
    logic          w_done;

    assign w_arm_ok      = arm & (r_state == S_IDLE);
    assign w_stb         = en & (r_div_cnt == 12'd0);
    assign w_post_target = (AW+1)'(DEPTH) - {1'b0, r_pl};
    assign w_post_done   = (r_post_cnt == w_post_target);
    // once the post count is reached the record is frozen, no further writes
    assign w_wr          = w_stb & ((r_state == S_FILL) | (r_state == S_WAIT) |
                                    ((r_state == S_POST) & ~w_post_done));
    assign w_rise        = r_prev_ok & (r_prev < trig_level) & (r_ad_q >= trig_level);
    assign w_fall        = r_prev_ok & (r_prev > trig_level) & (r_ad_q <= trig_level);
    assign w_edge        = r_edge_l ? w_fall : w_rise;
    // edge and force in one cycle collapse into a single trigger
    assign w_trig        = (r_state == S_WAIT) & ((w_stb & w_edge) | force_trig);
    assign w_fire        = r_out_v & rd_ready;
    // occupancy of out+skid after this edge; a new read may issue only if
    // its data is guaranteed a slot when it lands next cycle
    assign w_occ_nxt     = {1'b0, r_out_v} + {1'b0, r_sk_v} + {1'b0, r_ram_v} - {1'b0, w_fire};
    assign w_issue       = (r_state == S_READ) & (r_rd_issued != (AW+1)'(DEPTH)) &
                           (w_occ_nxt <= 2'd1);
    assign w_done        = w_fire & r_out_last;

    assign busy      = (r_state != S_IDLE);
    assign triggered = r_triggered;
    assign rd_data   = r_out_d;
    assign rd_valid  = r_out_v;
    assign rd_last   = r_out_last;

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (arm) w_state_nxt = (pre_len == '0) ? S_WAIT : S_FILL;
            S_FILL: if (w_stb && ((r_fill + AW'(1)) == r_pl)) w_state_nxt = S_WAIT;
            S_WAIT: if (w_trig) w_state_nxt = S_POST;
            S_POST: if (w_post_done) w_state_nxt = S_READ;
            S_READ: if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state register, decimator, write pointer, trigger and read-address control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ad_q      <= '0;
            r_div_cnt   <= '0;
            r_decim_l   <= '0;
            r_edge_l    <= 1'b0;
            r_pl        <= '0;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            r_prev      <= '0;
            r_prev_ok   <= 1'b0;
            r_trig_addr <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_issued <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ad_q  <= AD_DATA;

            if (w_arm_ok) begin
                r_div_cnt   <= '0;
                r_decim_l   <= decim;
                r_edge_l    <= trig_edge;
                r_pl        <= pre_len;
                r_fill      <= '0;
                r_triggered <= 1'b0;
                r_prev_ok   <= 1'b0;
            end else if (en) begin
                r_div_cnt <= (r_div_cnt >= r_decim_l) ? 12'd0 : r_div_cnt + 12'd1;
            end

            if ((r_state == S_FILL) && w_stb)
                r_fill <= r_fill + AW'(1);

            if (w_wr) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_prev    <= r_ad_q;
                r_prev_ok <= 1'b1;
            end

            // a strobe-aligned trigger stores its own sample now; a bare
            // force_trig points at the slot the next strobe will fill
            if (w_trig) begin
                r_triggered <= 1'b1;
                r_trig_addr <= r_wr_ptr;
                r_post_cnt  <= w_stb ? (AW+1)'(1) : '0;
            end else if ((r_state == S_POST) && w_wr) begin
                r_post_cnt <= r_post_cnt + (AW+1)'(1);
            end

            if ((r_state == S_POST) && w_post_done) begin
                r_rd_addr   <= r_trig_addr - r_pl;
                r_rd_issued <= '0;
            end else if (w_issue) begin
                r_rd_addr   <= r_rd_addr + AW'(1);
                r_rd_issued <= r_rd_issued + (AW+1)'(1);
            end
        end
    end

    // sample RAM: write port from the capture side, registered read port
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_ad_q;
        if (w_issue)
            r_ram_q <= r_mem[r_rd_addr];
    end

    // output register with skid so a stall never drops or repeats a sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_v    <= 1'b0;
            r_ram_last <= 1'b0;
            r_out_d    <= '0;
            r_out_v    <= 1'b0;
            r_out_last <= 1'b0;
            r_sk_d     <= '0;
            r_sk_v     <= 1'b0;
            r_sk_last  <= 1'b0;
        end else begin
            r_ram_v <= w_issue;
            if (w_issue)
                r_ram_last <= (r_rd_issued == (AW+1)'(DEPTH - 1));

            if (!r_out_v || rd_ready) begin
                if (r_sk_v) begin
                    r_out_d    <= r_sk_d;
                    r_out_v    <= 1'b1;
                    r_out_last <= r_sk_last;
                    r_sk_v     <= r_ram_v;
                    if (r_ram_v) begin
                        r_sk_d    <= r_ram_q;
                        r_sk_last <= r_ram_last;
                    end
                end else begin
                    r_out_v    <= r_ram_v;
                    r_out_last <= r_ram_v & r_ram_last;
                    if (r_ram_v)
                        r_out_d <= r_ram_q;
                end
            end else if (r_ram_v) begin
                r_sk_v    <= 1'b1;
                r_sk_d    <= r_ram_q;
                r_sk_last <= r_ram_last;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with a scoreboard queue of expected samples.
module tb_adc_capture;
    localparam int DW = 14;
    localparam int AW = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] AD_DATA;
    logic [11:0]   decim;
    logic [DW-1:0] trig_level;
    logic          trig_edge;
    logic [AW-1:0] pre_len;
    logic          arm;
    logic          force_trig;
    logic          busy;
    logic          triggered;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;

    adc_capture #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .AD_DATA(AD_DATA), .decim(decim),
        .trig_level(trig_level), .trig_edge(trig_edge), .pre_len(pre_len),
        .arm(arm), .force_trig(force_trig), .busy(busy), .triggered(triggered),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int d_hist[$];
    bit e_hist[$];
    int exp_q[$];
    int obs[DEPTH];
    int ad_acc = 0;
    int ad_step = 0;
    logic [15:0] lfsr = 16'hACE1;

    // what the DUT saw on each rising edge, index = edge number
    always @(posedge clk) begin
        d_hist.push_back(int'(AD_DATA));
        e_hist.push_back(en);
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        ad_acc  = (ad_acc + ad_step) & 16383;
        AD_DATA = ad_acc[DW-1:0];
    endtask

    task automatic do_arm(output int n0);
        tick();
        arm = 1'b1;
        n0  = d_hist.size();
        tick();
        arm = 1'b0;
    endtask

    // stored stream: in the cycle after edge n the register holds d[n]; it is
    // kept when en is high and the decimation phase is zero
    task automatic build_exp(input int n0, input int dec, input int pl,
                             input bit fall, input int lvl);
        int s[$];
        int div;
        int k;
        div = 0;
        k = -1;
        exp_q.delete();
        for (int n = n0; n + 1 < d_hist.size(); n++) begin
            if (e_hist[n+1]) begin
                if (div == 0) s.push_back(d_hist[n]);
                div = (div == dec) ? 0 : div + 1;
            end
        end
        for (int j = (pl > 1 ? pl : 1); j < s.size() && k < 0; j++) begin
            if (!fall && s[j-1] < lvl && s[j] >= lvl) k = j;
            if (fall && s[j-1] > lvl && s[j] <= lvl) k = j;
        end
        chk("model_record_available", (k >= 0) && (k - pl + DEPTH <= s.size()), 1);
        if ((k >= 0) && (k - pl + DEPTH <= s.size()))
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(s[k - pl + i]);
    endtask

    task automatic collect(input bit use_lfsr, input int n0, input int dec, input int pl,
                           input bit fall, input int lvl, input bit cst);
        int cnt;
        int t;
        int e;
        bit stalled;
        logic [DW-1:0] held_d;
        logic held_l;
        cnt = 0;
        t = 0;
        stalled = 0;
        held_d = '0;
        held_l = 1'b0;
        rd_ready = 1'b1;
        while (!rd_valid && t < 20000) begin
            tick();
            t++;
        end
        chk("first_valid_seen", rd_valid, 1);
        if (cst) begin
            exp_q.delete();
            repeat (DEPTH) exp_q.push_back(lvl);
        end else begin
            build_exp(n0, dec, pl, fall, lvl);
        end
        t = 0;
        while (cnt < DEPTH && t < 20000) begin
            if (stalled) begin
                chk("stall_valid", rd_valid, 1);
                chk("stall_data", rd_data, held_d);
                chk("stall_last", rd_last, held_l);
            end
            if (use_lfsr) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                rd_ready = lfsr[0];
            end
            if (rd_valid && rd_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                chk($sformatf("sample%0d", cnt), rd_data, e);
                chk($sformatf("rd_last%0d", cnt), rd_last, cnt == DEPTH - 1);
                obs[cnt] = int'(rd_data);
                cnt++;
            end
            stalled = rd_valid && !rd_ready;
            held_d  = rd_data;
            held_l  = rd_last;
            tick();
            t++;
        end
        chk("record_count", cnt, DEPTH);
        chk("end_rd_valid", rd_valid, 0);
        chk("end_busy", busy, 0);
        rd_ready = 1'b1;
    endtask

    task automatic step_errors(input int step, output int bad);
        bad = 0;
        for (int i = 0; i + 1 < DEPTH; i++)
            if (((obs[i+1] - obs[i]) & 16383) != (step & 16383)) bad++;
    endtask

    initial begin
        int n0;
        int t;
        int bad;
        rst = 1'b1; en = 1'b1; AD_DATA = '0; decim = '0; trig_level = '0;
        trig_edge = 1'b0; pre_len = '0; arm = 1'b0; force_trig = 1'b0; rd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();

        // 1: rising ramp, decim 0, 100 pre-trigger samples
        ad_acc = 0; ad_step = 64;
        decim = 12'd0; pre_len = 9'd100; trig_edge = 1'b0; trig_level = 14'd8192;
        do_arm(n0);
        chk("t1_busy_after_arm", busy, 1);
        collect(1'b0, n0, 0, 100, 1'b0, 8192, 1'b0);
        chk("t1_s100_ge_level", obs[100] >= 8192, 1);
        chk("t1_s99_lt_level", obs[99] < 8192, 1);
        chk("t1_triggered", triggered, 1);
        step_errors(64, bad);
        chk("t1_ramp_continuity", bad, 0);

        // 2: falling edge on descending ramp, decim 3, no history
        ad_acc = 16383; ad_step = -16;
        decim = 12'd3; pre_len = 9'd0; trig_edge = 1'b1; trig_level = 14'd4000;
        do_arm(n0);
        chk("t2_arm_clears_triggered", triggered, 0);
        collect(1'b0, n0, 3, 0, 1'b1, 4000, 1'b0);
        chk("t2_s0_le_level", obs[0] <= 4000, 1);
        step_errors(-64, bad);
        chk("t2_four_step_spacing", bad, 0);

        // 3: constant input, forced trigger
        ad_acc = 1000; ad_step = 0;
        decim = 12'd0; pre_len = 9'd200; trig_edge = 1'b0; trig_level = 14'd16000;
        do_arm(n0);
        repeat (600) tick();
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        chk("t3_triggered", triggered, 1);
        chk("t3_busy", busy, 1);
        collect(1'b0, n0, 0, 200, 1'b0, 1000, 1'b1);

        // 4: same setup as 1 with random back-pressure
        ad_acc = 0; ad_step = 64;
        decim = 12'd0; pre_len = 9'd100; trig_edge = 1'b0; trig_level = 14'd8192;
        do_arm(n0);
        collect(1'b1, n0, 0, 100, 1'b0, 8192, 1'b0);

        // 5: en pauses while waiting/posting, arm pulsed while busy
        ad_acc = 5000; ad_step = 32;
        decim = 12'd1; pre_len = 9'd50; trig_edge = 1'b0; trig_level = 14'd8192;
        do_arm(n0);
        repeat (150) tick();
        en = 1'b0;
        repeat (20) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (29) tick();
        en = 1'b1;
        repeat (500) tick();
        en = 1'b0;
        repeat (50) tick();
        en = 1'b1;
        chk("t5_busy_through_pause", busy, 1);
        collect(1'b0, n0, 1, 50, 1'b0, 8192, 1'b0);

        // 6: reset in POST, then in READ, then a clean capture
        ad_acc = 0; ad_step = 64;
        decim = 12'd0; pre_len = 9'd10; trig_edge = 1'b0; trig_level = 14'd8192;
        do_arm(n0);
        t = 0;
        while (!triggered && t < 3000) begin tick(); t++; end
        chk("t6_trigger_seen", triggered, 1);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        chk("t6_post_rst_busy", busy, 0);
        chk("t6_post_rst_rd_valid", rd_valid, 0);
        chk("t6_post_rst_triggered", triggered, 0);
        rst = 1'b0;
        rd_ready = 1'b0;
        do_arm(n0);
        t = 0;
        while (!rd_valid && t < 5000) begin tick(); t++; end
        chk("t6_read_reached", rd_valid, 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("t6_read_rst_busy", busy, 0);
        chk("t6_read_rst_rd_valid", rd_valid, 0);
        chk("t6_read_rst_triggered", triggered, 0);
        rst = 1'b0;
        rd_ready = 1'b1;
        pre_len = 9'd100;
        do_arm(n0);
        collect(1'b0, n0, 0, 100, 1'b0, 8192, 1'b0);
        chk("t6_fresh_triggered", triggered, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
